// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Two-flop synchronizer plus per-bit consecutive-sample debounce
//            for the slide-switch bank, with one-cycle rise/fall/changed pulses.
// Revision : 1.0  initial release
// ============================================================================

module switch_debouncer #(
  parameter int WIDTH           = 11,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // A single-cycle debounce still needs a one-bit counter, so the width floors at 1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches_raw;
      sync2 <= sync1;
    end
  end

  // Each bit is STABLE while its counter idles at zero and PENDING while the
  // synchronized level disagrees; any agreeing sample drops it back to STABLE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;

    assign accept[i] = (sync2[i] != switches[i]) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if ((sync2[i] == switches[i]) || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      switches <= '0;
      rise     <= '0;
      fall     <= '0;
      changed  <= 1'b0;
    end else begin
      switches <= switches ^ accept;
      rise     <= accept & ~switches;
      fall     <= accept & switches;
      changed  <= |accept;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Self-checking bench for switch_debouncer against a sample-window
//            reference model, with directed scenarios and random bouncing.
// Revision : 1.0  initial release
// ============================================================================

module tb_switch_debouncer;

  localparam int W = 11;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] switches_raw = '0;
  logic [W-1:0] switches, rise, fall;
  logic         changed;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw delay line, window of recent synchronized samples.
  logic [W-1:0] p1 = '0, p2 = '0;
  logic [W-1:0] sq[$];
  logic [W-1:0] m_sw = '0, m_rise = '0, m_fall = '0;
  logic         m_changed = 1'b0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .switches_raw (switches_raw),
    .switches     (switches),
    .rise         (rise),
    .fall         (fall),
    .changed      (changed)
  );

  always #5 clk = ~clk;

  // A level is accepted once the last D synchronized samples all disagree
  // with the current output level.
  task automatic model_edge();
    logic [W-1:0] s;
    bit all;
    if (rst) begin
      p1 = '0; p2 = '0; sq.delete();
      m_sw = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = switches_raw;
      sq.push_back(s);
      if (sq.size() > D) void'(sq.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        all = (sq.size() == D);
        for (int k = 0; k < sq.size(); k++)
          if (sq[k][b] == m_sw[b]) all = 0;
        if (all) begin
          if (m_sw[b]) m_fall[b] = 1'b1;
          else         m_rise[b] = 1'b1;
          m_sw[b] = ~m_sw[b];
        end
      end
      m_changed = |(m_rise | m_fall);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    switches_raw = 11'h7FF;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({switches, rise, fall, changed} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got sw=%h rise=%h fall=%h ch=%b want all 0",
                 c, switches, rise, fall, changed);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (e < 6 && (switches !== '0 || changed !== 1'b0)) begin
        errors++;
        $display("FAIL reset_early e=%0d got sw=%h ch=%b want 0", e, switches, changed);
      end else if (e == 6 && (switches !== 11'h7FF || rise !== 11'h7FF || changed !== 1'b1)) begin
        errors++;
        $display("FAIL reset_release e=%0d got sw=%h rise=%h ch=%b want 7ff 7ff 1",
                 e, switches, rise, changed);
      end else if (e > 6 && (switches !== 11'h7FF || rise !== '0 || changed !== 1'b0)) begin
        errors++;
        $display("FAIL reset_pulse_len e=%0d got sw=%h rise=%h ch=%b want 7ff 0 0",
                 e, switches, rise, changed);
      end
    end
  endtask

  task automatic settle_to(input logic [W-1:0] v);
    switches_raw = v;
    for (int c = 0; c < D + 6; c++) step();
    checks++;
    if (switches !== v) begin
      errors++;
      $display("FAIL settle got sw=%h want %h", switches, v);
    end
  endtask

  task automatic test_pattern();
    logic [W-1:0] pat;
    int hit;
    pat = 11'b1_1010101010;
    settle_to('0);
    switches_raw = pat;
    hit = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (switches === pat && hit == 0) begin
        hit = e;
        checks++;
        if (rise !== pat || fall !== '0 || changed !== 1'b1) begin
          errors++;
          $display("FAIL pattern_pulse got rise=%h fall=%h ch=%b want %h 0 1",
                   rise, fall, changed, pat);
        end
      end
      checks++;
      if ({switches, rise, fall, changed} !== {m_sw, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL pattern_model e=%0d got sw=%h r=%h f=%h c=%b want sw=%h r=%h f=%h c=%b",
                 e, switches, rise, fall, changed, m_sw, m_rise, m_fall, m_changed);
      end
    end
    checks++;
    if (hit != 6) begin
      errors++;
      $display("FAIL pattern_latency got %0d edges want 6", hit);
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] base;
    int hit;
    base = 11'b0_1010101010;
    settle_to(base);
    for (int t = 0; t < 4; t++) begin
      switches_raw = base | ((t % 2 == 0) ? 11'h400 : 11'h000);
      step();
      checks++;
      if (switches !== base || changed !== 1'b0) begin
        errors++;
        $display("FAIL bounce_quiet t=%0d got sw=%h ch=%b want %h 0", t, switches, changed, base);
      end
    end
    switches_raw = base | 11'h400;
    hit = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (switches[10] === 1'b1 && hit == 0) hit = e;
      checks++;
      if ({switches, rise, fall, changed} !== {m_sw, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL bounce_model e=%0d got sw=%h r=%h c=%b want sw=%h r=%h c=%b",
                 e, switches, rise, changed, m_sw, m_rise, m_changed);
      end
    end
    checks++;
    if (hit != 6) begin
      errors++;
      $display("FAIL bounce_latency got %0d edges want 6", hit);
    end
  endtask

  task automatic test_glitch();
    settle_to('0);
    for (int c = 0; c < 12; c++) begin
      switches_raw = (c < 3) ? 11'h008 : 11'h000;
      step();
      checks++;
      if (switches !== '0 || rise !== '0 || fall !== '0 || changed !== 1'b0) begin
        errors++;
        $display("FAIL glitch c=%0d got sw=%h r=%h f=%h ch=%b want all 0",
                 c, switches, rise, fall, changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    int hit;
    settle_to(11'h001);
    switches_raw = 11'h200;
    hit = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (changed === 1'b1) begin
        hit++;
        checks++;
        if (fall !== 11'h001 || rise !== 11'h200 || switches !== 11'h200) begin
          errors++;
          $display("FAIL simul_pulse e=%0d got sw=%h r=%h f=%h want 200 200 001",
                   e, switches, rise, fall);
        end
      end
    end
    checks++;
    if (hit != 1) begin
      errors++;
      $display("FAIL simul_changed_count got %0d pulses want 1", hit);
    end
  endtask

  task automatic test_reset_mid_count();
    int hit;
    settle_to('0);
    switches_raw = 11'h020;
    for (int e = 0; e < 4; e++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({switches, rise, fall, changed} !== '0 || dut.g_bit[5].cnt !== '0) begin
      errors++;
      $display("FAIL midreset got sw=%h ch=%b cnt5=%0d want 0", switches, changed,
               dut.g_bit[5].cnt);
    end
    rst = 1'b0;
    hit = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (switches[5] === 1'b1 && hit == 0) hit = e;
    end
    checks++;
    if (hit != 6) begin
      errors++;
      $display("FAIL midreset_latency got %0d edges want 6", hit);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        switches_raw = switches_raw ^ W'($urandom & $urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if ({switches, rise, fall, changed} !== {m_sw, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL random c=%0d got sw=%h r=%h f=%h c=%b want sw=%h r=%h f=%h c=%b",
                 c, switches, rise, fall, changed, m_sw, m_rise, m_fall, m_changed);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
